// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that feeds frames from two requesters
// into a single UART transmitter, one frame at a time.
// Optional feature macro: UART_ARB_TIMEOUT_EN adds a start timeout in
// WAIT_BUSY (timeout_err pulses when tx_busy never rises after a launch).
module uart_tx_arbiter #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int START_TIMEOUT    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req0_valid,
    input  logic [INPUT_DATA_WIDTH-1:0] req0_data,
    output logic                        req0_ready,
    input  logic                        req1_valid,
    input  logic [INPUT_DATA_WIDTH-1:0] req1_data,
    output logic                        req1_ready,
    output logic                        tx_enable,
    output logic [INPUT_DATA_WIDTH-1:0] tx_data,
    input  logic                        tx_busy,
    output logic                        frame_done,
    output logic                        frame_src,
    output logic                        active,
    output logic                        timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic                        last_grant;
    logic                        grant;
    logic                        take;
    logic                        wait_expired;
    logic [INPUT_DATA_WIDTH-1:0] data_q;
    logic                        src_q;

    // Pick the requester to serve: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = (state == IDLE) && !reset && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && !reset && req1_valid && grant;
    assign take       = req0_ready || req1_ready;

    assign active    = (state != IDLE);
    assign tx_data   = data_q;
    assign frame_src = src_q;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(START_TIMEOUT + 1);
    logic [CW-1:0] wait_count;

    assign wait_expired = (wait_count == CW'(START_TIMEOUT));

    // Count cycles spent waiting for the transmitter to go busy; zero outside WAIT_BUSY
    always_ff @(posedge clk) begin
        if (reset || (state != WAIT_BUSY)) begin
            wait_count <= '0;
        end else if (!wait_expired) begin
            wait_count <= wait_count + CW'(1);
        end
    end
`else
    assign wait_expired = 1'b0;
`endif

    // Next-state and strobe decode; reset suppresses every strobe in its own cycle
    always_comb begin
        state_next  = state;
        tx_enable   = 1'b0;
        frame_done  = 1'b0;
        timeout_err = 1'b0;
        case (state)
            IDLE: begin
                if (take) state_next = LAUNCH;
            end
            LAUNCH: begin
                if (!tx_busy) begin
                    tx_enable  = 1'b1;
                    state_next = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (wait_expired) begin
                    timeout_err = 1'b1;
                    state_next  = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            state_next  = IDLE;
            tx_enable   = 1'b0;
            frame_done  = 1'b0;
            timeout_err = 1'b0;
        end
    end

    // State register, captured frame and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            data_q     <= '0;
            src_q      <= 1'b0;
        end else begin
            state <= state_next;
            if (take) begin
                data_q     <= grant ? req1_data : req0_data;
                src_q      <= grant;
                last_grant <= grant;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with a simple
// behavioural UART busy model. Define UART_ARB_TIMEOUT_EN to add the timeout case.
module tb_uart_tx_arbiter;

    localparam int W   = 8;
    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid;
    logic [W-1:0] req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_data;
    logic         req1_ready;
    logic         tx_enable;
    logic [W-1:0] tx_data;
    logic         tx_busy = 1'b0;
    logic         frame_done;
    logic         frame_src;
    logic         active;
    logic         timeout_err;

    uart_tx_arbiter #(
        .INPUT_DATA_WIDTH(W),
        .START_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req0_valid(req0_valid),
        .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data(req1_data),
        .req1_ready(req1_ready),
        .tx_enable(tx_enable),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .frame_done(frame_done),
        .frame_src(frame_src),
        .active(active),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         src;
        logic [W-1:0] data;
        int           lat;
        int           blen;
        bit           tmo;
    } exp_t;

    exp_t exp_q[$];

    int checks_total  = 0;
    int checks_passed = 0;
    int cycle_no      = 0;
    int busy_len      = 8;
    int force_arm     = 0;
    bit no_rise       = 1'b0;
    bit accept_flag   = 1'b0;
    bit launch_flag   = 1'b0;
    bit reset_seen    = 1'b0;
    int force_left    = 0;
    int busy_left     = 0;
    bit in_flight     = 1'b0;
    bit launched      = 1'b0;
    int acc_cycle     = 0;
    int launch_cycle  = 0;
    int evt_count     = 0;
    int accept_count  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cycle_no);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic pushExpected(input logic src, input logic [W-1:0] data, input int lat, input bit tmo);
        exp_t e;
        e.src  = src;
        e.data = data;
        e.lat  = lat;
        e.blen = busy_len;
        e.tmo  = tmo;
        exp_q.push_back(e);
    endtask

    // Drive requests, drop them once n frames are accepted, wait for n completions
    task automatic applyStimulus(input logic v0, input logic v1, input logic [W-1:0] d0,
                                 input logic [W-1:0] d1, input int n, input int budget);
        int acc0;
        int evt0;
        int cyc;
        acc0 = accept_count;
        evt0 = evt_count;
        cyc  = 0;
        @(posedge clk); #1;
        req0_valid = v0;
        req1_valid = v1;
        req0_data  = d0;
        req1_data  = d1;
        while (((evt_count - evt0) < n) && (cyc < budget)) begin
            @(posedge clk); #1;
            cyc++;
            if ((accept_count - acc0) >= n) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
                req0_data  = ~d0;
                req1_data  = ~d1;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkOutput("events_seen", evt_count - evt0, n);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_tx_enable"}, tx_enable, 0);
        checkOutput({tag, "_frame_done"}, frame_done, 0);
        checkOutput({tag, "_active"}, active, 0);
        checkOutput({tag, "_timeout_err"}, timeout_err, 0);
        checkOutput({tag, "_tx_data"}, tx_data, 0);
        checkOutput({tag, "_frame_src"}, frame_src, 0);
        checkOutput({tag, "_ready"}, {req0_ready, req1_ready}, 0);
    endtask

    // Cycle counter used for latency measurements
    always @(posedge clk) cycle_no++;

    // UART busy model: tx_busy rises the cycle after tx_enable and stays high busy_len cycles;
    // force_arm holds tx_busy high for that many cycles starting at LAUNCH entry
    always @(posedge clk) begin
        #1;
        if (reset_seen) begin
            busy_left   = 0;
            force_left  = 0;
            accept_flag = 1'b0;
            launch_flag = 1'b0;
            reset_seen  = 1'b0;
        end else begin
            if (force_left > 0) force_left--;
            else if (accept_flag && (force_arm > 0)) begin
                force_left = force_arm;
                force_arm  = 0;
            end
            accept_flag = 1'b0;
            if (busy_left > 0) busy_left--;
            else if (launch_flag && !no_rise) busy_left = busy_len;
            launch_flag = 1'b0;
        end
        tx_busy = (busy_left > 0) || (force_left > 0);
    end

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            reset_seen = 1'b1;
        end else begin
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                accept_count++;
                accept_flag = 1'b1;
                acc_cycle   = cycle_no;
                checkOutput("ready_onehot", {31'd0, req0_ready && req1_ready}, 0);
                if (exp_q.size() == 0) checkOutput("accept_unexpected", 1, 0);
                else begin
                    checkOutput("grant_src", req1_ready, exp_q[0].src);
                    checkOutput("accept_while_busy", in_flight, 0);
                end
                in_flight = 1'b1;
                launched  = 1'b0;
            end
            if (tx_enable) begin
                launch_flag  = 1'b1;
                launch_cycle = cycle_no;
                checkOutput("launch_busy", tx_busy, 0);
                checkOutput("launch_twice", launched, 0);
                checkOutput("launch_active", active, 1);
                if (exp_q.size() == 0) checkOutput("launch_unexpected", 1, 0);
                else begin
                    checkOutput("tx_data", tx_data, exp_q[0].data);
                    checkOutput("launch_lat", cycle_no - acc_cycle, exp_q[0].lat);
                end
                launched = 1'b1;
            end
            if (frame_done || timeout_err) begin
                if (exp_q.size() == 0) checkOutput("event_unexpected", {frame_done, timeout_err}, 0);
                else begin
                    checkOutput("event_kind", {frame_done, timeout_err}, exp_q[0].tmo ? 2'b01 : 2'b10);
                    checkOutput("event_lat", cycle_no - launch_cycle,
                                exp_q[0].tmo ? TMO + 1 : exp_q[0].blen + 1);
                    checkOutput("tx_data_hold", tx_data, exp_q[0].data);
                    if (frame_done) checkOutput("frame_src", frame_src, exp_q[0].src);
                    void'(exp_q.pop_front());
                end
                in_flight = 1'b0;
                launched  = 1'b0;
                evt_count++;
            end
        end
    end

    initial begin
        int acc0;
        int cyc;
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkIdleOutputs("reset");

        // Contention straight out of reset: requester 0 wins the first tie
        $display("[TB] contention");
        busy_len = 10;
        pushExpected(1'b0, 8'h11, 1, 1'b0);
        pushExpected(1'b1, 8'h22, 1, 1'b0);
        pushExpected(1'b0, 8'h11, 1, 1'b0);
        pushExpected(1'b1, 8'h22, 1, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h11, 8'h22, 4, 400);

        // Single request with a long busy period
        $display("[TB] single request");
        busy_len = 88;
        pushExpected(1'b0, 8'hA5, 1, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'hA5, 8'h00, 1, 300);

        // Transmitter busy when LAUNCH is entered: launch held off 5 cycles
        $display("[TB] busy at launch");
        busy_len  = 6;
        force_arm = 5;
        pushExpected(1'b1, 8'h3C, 6, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h3C, 1, 200);
        pushExpected(1'b0, 8'hC3, 1, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'hC3, 8'h00, 1, 200);

        // Reset while the frame is in WAIT_DONE
        $display("[TB] reset mid-frame");
        busy_len = 30;
        pushExpected(1'b0, 8'h77, 1, 1'b0);
        acc0 = accept_count;
        cyc  = 0;
        @(posedge clk); #1;
        req0_valid = 1'b1;
        req0_data  = 8'h77;
        while ((accept_count == acc0) && (cyc < 20)) begin
            @(posedge clk); #1;
            cyc++;
        end
        req0_valid = 1'b0;
        checkOutput("reset_test_accept", accept_count - acc0, 1);
        repeat (12) @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        in_flight = 1'b0;
        launched  = 1'b0;
        @(negedge clk);
        checkIdleOutputs("post_reset");
        busy_len = 5;
        pushExpected(1'b0, 8'h66, 1, 1'b0);
        pushExpected(1'b1, 8'h99, 1, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h66, 8'h99, 2, 200);

`ifdef UART_ARB_TIMEOUT_EN
        // Transmitter never goes busy: timeout, then a normal frame is still accepted
        $display("[TB] start timeout");
        no_rise = 1'b1;
        pushExpected(1'b1, 8'h5A, 1, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h5A, 1, 100);
        no_rise  = 1'b0;
        busy_len = 4;
        pushExpected(1'b0, 8'hE1, 1, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'hE1, 8'h00, 1, 100);
`endif

        repeat (5) @(posedge clk);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
